// File: rtl/cnt_arb_ctrl.sv
// cnt_arb_ctrl: two-requester round-robin arbiter in front of an N-bit counter.
// An accepted command either updates the count at once (STEP, CLEAR, LOAD)
// or starts a RUN that adds `arg` increments, one every DIV clocks.
//
// Handshake: a requester raises req[i] with cmd/arg and holds all three
// stable until it sees gnt[i] high for one cycle. cmd/arg are consumed at
// the same edge that raises gnt[i]. Requests are only looked at in IDLE
// while gnt is low, so there is always at least one cycle between grants.
// Requests made at any other time are ignored, not queued.
//
// DIV must lie in 1..255 so that the 8-bit prescaler can reach DIV-1.
module cnt_arb_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [1:0]   cmd0,
    input  logic [1:0]   cmd1,
    input  logic [N-1:0] arg0,
    input  logic [N-1:0] arg1,
    input  logic         abort,
    output logic [1:0]   gnt,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         wrap,
    output logic         state_dbg_o
);

    localparam logic [1:0] CMD_STEP  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_RUN   = 2'b11;

    localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] remaining_q, remaining_d;
    logic [7:0]   presc_q, presc_d;
    logic         ptr_q, ptr_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;

    logic         arb_en;
    logic         win;
    logic [1:0]   win_cmd;
    logic [N-1:0] win_arg;
    logic [N-1:0] count_inc;
    logic         count_max;

    // A grant is only possible in IDLE and never in the cycle right after one.
    assign arb_en = (state_q == S_IDLE) && (gnt_q == 2'b00) && (req != 2'b00);

    // A lone requester wins outright; on a tie the pointer decides.
    assign win     = (req == 2'b11) ? ptr_q : req[1];
    assign win_cmd = win ? cmd1 : cmd0;
    assign win_arg = win ? arg1 : arg0;

    assign count_inc = count_q + N'(1);
    assign count_max = &count_q;

    // Next-state and registered-output logic for the IDLE/RUN controller.
    always_comb begin
        state_d     = state_q;
        gnt_d       = 2'b00;
        count_d     = count_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        ptr_d       = ptr_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_en) begin
                    gnt_d = win ? 2'b10 : 2'b01;
                    ptr_d = ~win;
                    case (win_cmd)
                        CMD_STEP: begin
                            count_d = count_inc;
                            wrap_d  = count_max;
                        end
                        CMD_CLEAR: count_d = '0;
                        CMD_LOAD:  count_d = win_arg;
                        CMD_RUN: begin
                            if (win_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = win_arg;
                                presc_d     = 8'd0;
                                state_d     = S_RUN;
                            end
                        end
                        default: count_d = count_q;
                    endcase
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Abort wins over a due increment; the count is frozen.
                    state_d = S_IDLE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d     = 8'd0;
                    count_d     = count_inc;
                    wrap_d      = count_max;
                    remaining_d = remaining_q - N'(1);
                    if (remaining_q == N'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any run without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            count_q     <= '0;
            remaining_q <= '0;
            presc_q     <= 8'd0;
            ptr_q       <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign gnt         = gnt_q;
    assign count       = count_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign wrap        = wrap_q;
    assign state_dbg_o = (state_q == S_RUN);

endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Testbench for cnt_arb_ctrl: directed scenarios plus a randomized run,
// all compared against an event-level reference model.
module tb_cnt_arb_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    localparam logic [1:0] STEP  = 2'b00;
    localparam logic [1:0] CLEAR = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] RUN   = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [1:0]   cmd0 = 2'b00;
    logic [1:0]   cmd1 = 2'b00;
    logic [N-1:0] arg0 = '0;
    logic [N-1:0] arg1 = '0;
    logic         abort = 1'b0;
    logic [1:0]   gnt;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
    logic         wrap;
    logic         state_dbg;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    cnt_arb_ctrl #(.N(N), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cmd0        (cmd0),
        .cmd1        (cmd1),
        .arg0        (arg0),
        .arg1        (arg1),
        .abort       (abort),
        .gnt         (gnt),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .wrap        (wrap),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks a run as "cycles elapsed since the grant" and "increments made";
    // an increment lands on every multiple of DIV elapsed cycles.
    bit         m_idle    = 1'b1;
    logic [1:0] m_gnt     = 2'b00;
    int         m_count   = 0;
    bit         m_done    = 1'b0;
    bit         m_wrap    = 1'b0;
    bit         m_ptr     = 1'b0;
    int         m_elapsed = 0;
    int         m_len     = 0;
    int         m_incs    = 0;

    always @(posedge clk or negedge rst) begin : ref_model
        logic       w;
        logic [1:0] c;
        int         a;
        logic [1:0] g_prev;
        if (!rst) begin
            m_idle = 1'b1; m_gnt = 2'b00; m_count = 0; m_done = 1'b0;
            m_wrap = 1'b0; m_ptr = 1'b0; m_elapsed = 0; m_len = 0; m_incs = 0;
        end else begin
            g_prev = m_gnt;
            m_gnt  = 2'b00;
            m_done = 1'b0;
            m_wrap = 1'b0;
            if (!m_idle) begin
                if (abort) begin
                    m_idle = 1'b1;
                end else begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed % DIV == 0) begin
                        m_wrap  = (m_count == (1 << N) - 1);
                        m_count = (m_count + 1) % (1 << N);
                        m_incs  = m_incs + 1;
                        if (m_incs == m_len) begin
                            m_idle = 1'b1;
                            m_done = 1'b1;
                        end
                    end
                end
            end else if (g_prev == 2'b00 && req != 2'b00) begin
                w = (req == 2'b11) ? m_ptr : req[1];
                m_ptr = ~w;
                m_gnt = w ? 2'b10 : 2'b01;
                c = w ? cmd1 : cmd0;
                a = w ? int'(arg1) : int'(arg0);
                case (c)
                    STEP: begin
                        m_wrap  = (m_count == (1 << N) - 1);
                        m_count = (m_count + 1) % (1 << N);
                    end
                    CLEAR: m_count = 0;
                    LOAD:  m_count = a;
                    default: begin
                        if (a == 0) begin
                            m_done = 1'b1;
                        end else begin
                            m_idle = 1'b0; m_len = a; m_incs = 0; m_elapsed = 0;
                        end
                    end
                endcase
            end
        end
    end

    logic [N+4:0] obs;
    logic [N+4:0] exp_vec;
    assign obs     = {gnt, count, busy, done, wrap};
    assign exp_vec = {m_gnt, N'(m_count), ~m_idle, m_done, m_wrap};

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; cmd0 = STEP; cmd1 = STEP; arg0 = '0; arg1 = '0; abort = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        req = 2'b11; cmd0 = STEP; cmd1 = LOAD; arg1 = 4'd7;
        repeat (3) begin
            cycle();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_hold got %b want %b", obs, {(N+5){1'b0}});
            end
        end
        idle_inputs();
        rst = 1'b1;
        repeat (2) begin
            cycle();
            checks++;
            if (obs !== '0 || obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_idle got %b want %b", obs, {(N+5){1'b0}});
            end
        end
    endtask

    task automatic test_load_step();
        req = 2'b01; cmd0 = LOAD; arg0 = 4'd9;
        cycle();
        checks++;
        if ({gnt, count, wrap} !== {2'b01, 4'd9, 1'b0} || obs !== exp_vec) begin
            errors++;
            $display("FAIL load9 got gnt=%b count=%0d wrap=%b want gnt=01 count=9 wrap=0", gnt, count, wrap);
        end
        cmd0 = STEP;
        cycle();
        checks++;
        if ({gnt, count} !== {2'b00, 4'd9} || obs !== exp_vec) begin
            errors++;
            $display("FAIL load9_gap got gnt=%b count=%0d want gnt=00 count=9", gnt, count);
        end
        cycle();
        checks++;
        if ({gnt, count, wrap} !== {2'b01, 4'd10, 1'b0} || obs !== exp_vec) begin
            errors++;
            $display("FAIL step10 got gnt=%b count=%0d wrap=%b want gnt=01 count=10 wrap=0", gnt, count, wrap);
        end
        req = 2'b00;
        cycle();
    endtask

    task automatic test_wrap();
        req = 2'b01; cmd0 = LOAD; arg0 = 4'd15;
        cycle();
        cmd0 = STEP;
        cycle();
        cycle();
        checks++;
        if ({gnt, count, wrap} !== {2'b01, 4'd0, 1'b1} || obs !== exp_vec) begin
            errors++;
            $display("FAIL step_wrap got gnt=%b count=%0d wrap=%b want gnt=01 count=0 wrap=1", gnt, count, wrap);
        end
        cmd0 = CLEAR;
        cycle();
        checks++;
        if (wrap !== 1'b0 || obs !== exp_vec) begin
            errors++;
            $display("FAIL wrap_pulse_len got wrap=%b want 0", wrap);
        end
        cycle();
        checks++;
        if ({gnt, count, wrap} !== {2'b01, 4'd0, 1'b0} || obs !== exp_vec) begin
            errors++;
            $display("FAIL clear got gnt=%b count=%0d wrap=%b want gnt=01 count=0 wrap=0", gnt, count, wrap);
        end
        req = 2'b00;
        cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]   exp_g;
        logic [N-1:0] exp_c;
        apply_reset();
        req = 2'b11; cmd0 = STEP; cmd1 = STEP;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            exp_g = (k % 2 == 0) ? 2'b00 : ((((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
            exp_c = N'((k + 1) / 2);
            checks++;
            if ({gnt, count} !== {exp_g, exp_c} || obs !== exp_vec) begin
                errors++;
                $display("FAIL rr_k%0d got gnt=%b count=%0d want gnt=%b count=%0d", k, gnt, count, exp_g, exp_c);
            end
        end
        req = 2'b00;
        cycle();
    endtask

    task automatic test_run();
        logic [N-1:0] prev_c;
        logic [N-1:0] exp_c;
        logic [N-1:0] want;
        int           incs;
        req = 2'b01; cmd0 = LOAD; arg0 = 4'd14;
        cycle();
        cmd0 = RUN; arg0 = 4'd3;
        cycle();
        cycle();
        checks++;
        if ({gnt, count, busy, done} !== {2'b01, 4'd14, 1'b1, 1'b0} || obs !== exp_vec) begin
            errors++;
            $display("FAIL run_grant got gnt=%b count=%0d busy=%b done=%b want 01 14 1 0", gnt, count, busy, done);
        end
        req = 2'b00;
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        prev_c = count;
        for (int t = 1; t <= 14; t++) begin
            if (t == 2) begin
                req = 2'b10; cmd1 = STEP;
            end
            cycle();
            incs  = (t / 4 > 3) ? 3 : t / 4;
            exp_c = N'((14 + incs + ((t >= 13) ? 1 : 0)) % 16);
            checks++;
            if ({gnt, count, busy, done, wrap} !==
                {((t == 13) ? 2'b10 : 2'b00), exp_c, (t < 12), (t == 12), (t == 8)} ||
                obs !== exp_vec) begin
                errors++;
                $display("FAIL run_t%0d got %b want %b", t,
                         {gnt, count, busy, done, wrap},
                         {((t == 13) ? 2'b10 : 2'b00), exp_c, (t < 12), (t == 12), (t == 8)});
            end
            if (t <= 12 && count !== prev_c) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (count !== want) begin
                    errors++;
                    $display("FAIL run_seq_t%0d got %0d want %0d", t, count, want);
                end
            end
            prev_c = count;
            if (t == 13) req = 2'b00;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_seq_left got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_abort_and_zero();
        int           start;
        int           incs;
        logic [N-1:0] exp_c;
        logic         exp_w;
        start = int'($urandom_range(0, 15));
        req = 2'b10; cmd1 = LOAD; arg1 = N'(start);
        cycle();
        cmd1 = RUN; arg1 = 4'd5;
        cycle();
        cycle();
        req = 2'b00;
        for (int t = 1; t <= 12; t++) begin
            if (t == 9)  abort = 1'b1;
            if (t == 10) abort = 1'b0;
            cycle();
            incs  = (t < 9) ? t / 4 : 2;
            exp_c = N'((start + incs) % 16);
            exp_w = (t == 4 || t == 8) && ((start + t / 4 - 1) % 16 == 15);
            checks++;
            if ({busy, done, count, wrap} !== {(t < 9), 1'b0, exp_c, exp_w} || obs !== exp_vec) begin
                errors++;
                $display("FAIL abort_t%0d got busy=%b done=%b count=%0d wrap=%b want %b 0 %0d %b",
                         t, busy, done, count, wrap, (t < 9), exp_c, exp_w);
            end
        end
        // Zero-length run completes at once; abort is meaningless in IDLE.
        req = 2'b10; cmd1 = RUN; arg1 = '0; abort = 1'b1;
        cycle();
        exp_c = N'((start + 2) % 16);
        checks++;
        if ({gnt, busy, done, count} !== {2'b10, 1'b0, 1'b1, exp_c} || obs !== exp_vec) begin
            errors++;
            $display("FAIL run_zero got gnt=%b busy=%b done=%b count=%0d want 10 0 1 %0d", gnt, busy, done, count, exp_c);
        end
        cmd1 = STEP;
        cycle();
        checks++;
        if (done !== 1'b0 || obs !== exp_vec) begin
            errors++;
            $display("FAIL done_pulse_len got done=%b want 0", done);
        end
        cycle();
        exp_c = N'((start + 3) % 16);
        exp_w = ((start + 2) % 16 == 15);
        checks++;
        if ({gnt, busy, count, wrap} !== {2'b10, 1'b0, exp_c, exp_w} || obs !== exp_vec) begin
            errors++;
            $display("FAIL abort_idle_step got gnt=%b busy=%b count=%0d wrap=%b want 10 0 %0d %b", gnt, busy, count, wrap, exp_c, exp_w);
        end
        abort = 1'b0; req = 2'b00;
        cycle();
    endtask

    task automatic test_reset_mid_run();
        req = 2'b01; cmd0 = RUN; arg0 = 4'd7;
        cycle();
        req = 2'b00;
        repeat (5) cycle();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || obs !== exp_vec) begin
            errors++;
            $display("FAIL async_reset got %b want %b", obs, {(N+5){1'b0}});
        end
        cycle();
        rst = 1'b1;
        req = 2'b11; cmd0 = STEP; cmd1 = STEP;
        cycle();
        checks++;
        if ({gnt, count, done} !== {2'b01, 4'd1, 1'b0} || obs !== exp_vec) begin
            errors++;
            $display("FAIL post_reset_grant got gnt=%b count=%0d done=%b want 01 1 0", gnt, count, done);
        end
        req = 2'b00;
        cycle();
    endtask

    task automatic test_random();
        req = 2'b00; abort = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (gnt[0]) begin
                req[0] = ($urandom_range(0, 3) != 0);
                cmd0 = 2'($urandom_range(0, 3)); arg0 = N'($urandom_range(0, 15));
            end else if (!req[0] && $urandom_range(0, 2) == 0) begin
                req[0] = 1'b1;
                cmd0 = 2'($urandom_range(0, 3)); arg0 = N'($urandom_range(0, 15));
            end
            if (gnt[1]) begin
                req[1] = ($urandom_range(0, 3) != 0);
                cmd1 = 2'($urandom_range(0, 3)); arg1 = N'($urandom_range(0, 15));
            end else if (!req[1] && $urandom_range(0, 2) == 0) begin
                req[1] = 1'b1;
                cmd1 = 2'($urandom_range(0, 3)); arg1 = N'($urandom_range(0, 15));
            end
            abort = ($urandom_range(0, 29) == 0);
            cycle();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_i%0d got %b want %b", i, obs, exp_vec);
            end
        end
        idle_inputs();
        cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_step();
        test_wrap();
        test_round_robin();
        test_run();
        test_abort_and_zero();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnt_arb_ctrl.md
CNT_ARB_CTRL -- requirements
Module: cnt_arb_ctrl

Interface
REQ-001 Parameter N, default 4: width of the count register and load/length operands.
REQ-002 Parameter DIV, default 4: clock cycles per increment in RUN mode; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  request per requester; bit i = requester i.
REQ-006 cmd0, cmd1  input  2 each  command of requester 0/1: 00 STEP, 01 CLEAR, 10 LOAD, 11 RUN.
REQ-007 arg0, arg1  input  N each  operand of requester 0/1: load value for LOAD, increment count for RUN.
REQ-008 abort  input  1  synchronous abort of a RUN in progress.
REQ-009 gnt  output  2  one-cycle grant pulse; bit i = requester i accepted.
REQ-010 count  output  N  current count value, intended to drive the 7-segment decoder.
REQ-011 busy  output  1  high while in RUN state.
REQ-012 done  output  1  one-cycle pulse when a RUN completes normally.
REQ-013 wrap  output  1  one-cycle pulse on any increment from 2^N-1 to 0.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN.
REQ-015 Arbitration SHALL occur only in IDLE, with gnt==0 and req!=0; requests in any other cycle are ignored, not queued.
REQ-016 A single active requester SHALL win; when both are active, the requester indicated by the round-robin pointer wins.
REQ-017 After every grant, the pointer SHALL move to the non-winning requester.
REQ-018 At the arbitration edge: gnt[winner]<=1 for exactly one cycle, and cmd/arg of the winner are sampled at the same edge.
REQ-019 Requesters SHALL hold req, cmd and arg stable until they see gnt, then deassert req or present a new command.
REQ-020 STEP: count<=count+1 (mod 2^N) at the grant edge; the state remains IDLE.
REQ-021 CLEAR: count<=0 at the grant edge; the state remains IDLE.
REQ-022 LOAD: count<=arg at the grant edge; the state remains IDLE.
REQ-023 RUN with arg==0: count is unchanged, done<=1 for one cycle, and the state remains IDLE.
REQ-024 RUN with arg!=0: remaining<=arg, prescaler<=0, state<=RUN, busy<=1, all at the grant edge.
REQ-025 In RUN, the prescaler SHALL count 0..DIV-1. When prescaler==DIV-1 the block SHALL set count<=count+1, remaining<=remaining-1 and prescaler<=0. The first increment therefore occurs DIV cycles after the grant edge.
REQ-026 In RUN, when an increment occurs with remaining==1: state<=IDLE, busy<=0 and done<=1 at that edge. Arbitration may resume in the following cycle.
REQ-027 In RUN with abort==1: state<=IDLE and busy<=0 at that edge. count keeps its value, done is not asserted, and no increment occurs in that cycle even if the prescaler is due.
REQ-028 abort in IDLE SHALL have no effect.
REQ-029 wrap SHALL pulse in the same cycle that count changes from 2^N-1 to 0 via STEP or a RUN increment; CLEAR and LOAD never assert wrap.
REQ-030 gnt, done and wrap SHALL be registered outputs, each high for at most one cycle per event.
REQ-031 count SHALL be registered and SHALL change only on the edges defined in REQ-020..REQ-027.

Reset
REQ-032 While rst==0, the block SHALL set: state IDLE, count 0, gnt 0, busy 0, done 0, wrap 0, pointer = requester 0, prescaler 0, remaining 0.
REQ-033 Assertion of rst during RUN SHALL abandon the run immediately without asserting done.
REQ-034 After rst deasserts, the first arbitration SHALL occur on the first rising edge at which req!=0.

Verification
REQ-035 Reset, then requester 0 issues LOAD arg=9 -> gnt=01 for one cycle, count=9, then STEP -> count=10, wrap=0.
REQ-036 LOAD arg=15, then STEP -> count=0 with a one-cycle wrap pulse; then CLEAR -> count=0, wrap=0.
REQ-037 Both req held with STEP; start from reset -> grants alternate 01,10,01,10, each separated by at least one idle cycle, and count increments once per grant.
REQ-038 DIV=4, RUN arg=3 from count=14 -> increments 4, 8 and 12 cycles after the grant; count sequence 15, 0 (wrap), 1; busy high for 12 cycles; done pulses with the final increment; req[1] raised during RUN is granted only after done.
REQ-039 RUN arg=5, abort asserted after 2 increments -> busy drops at that edge, count=start+2, done never asserted; RUN arg=0 -> immediate done, count unchanged.
REQ-040 Assert rst mid-RUN -> all outputs 0 asynchronously; after release, req[0] and req[1] asserted together -> requester 0 is granted first.
